rx_deframe_fifo: RTL
====================

RX_DEFRAME_FIFO -- requirements
Module: rx_deframe_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 8, maximum data bits per frame (5..8).
REQ-002 SHALL have parameter DEPTH, default 4, number of buffered frames (power of 2, >=2).
REQ-003 SHALL have parameter FRAME_W, default DATA_W+4, frame input width: start + data + parity + 2 stop.
REQ-004 Clk  input  1  rising-edge clock.
REQ-005 ResetN  input  1  reset, asynchronous, active-low.
REQ-006 FrameValid  input  1  one-cycle strobe, FrameIn holds a complete received frame.
REQ-007 FrameIn  input  FRAME_W  received frame, bit 0 = start bit (first on line), data LSB-first from bit 1.
REQ-008 DataLength  input  2  00=5, 01=6, 10=7, 11=8 data bits (values above DATA_W clamp to DATA_W).
REQ-009 ParityType  input  2  00=none, 01=odd, 10=even, 11=none.
REQ-010 StopBits  input  1  0=one stop bit, 1=two stop bits.
REQ-011 RxReady  input  1  consumer accepts head entry.
REQ-012 ClearOverrun  input  1  synchronous clear of Overrun.
REQ-013 RxValid  output  1  head entry available.
REQ-014 RxData  output  DATA_W  head data, zero-extended above active length.
REQ-015 RxParityErr  output  1  head entry parity error.
REQ-016 RxFrameErr  output  1  head entry start/stop error.
REQ-017 Overrun  output  1  sticky: a frame was dropped.
REQ-018 Count  output  $clog2(DEPTH)+1  entries held.

Function
REQ-019 Config (DataLength, ParityType, StopBits) SHALL be sampled only in the cycle FrameValid=1; changes at other times have no effect on stored entries.
REQ-020 With N active data bits: data = FrameIn[N:1]; parity bit at FrameIn[N+1] when enabled; stop bit(s) follow at next one or two positions; FrameIn bits above frame end SHALL be ignored.
REQ-021 Parity check: odd -> error when XOR(data,parity)=0; even -> error when XOR(data,parity)=1; none -> RxParityErr=0 always.
REQ-022 RxFrameErr SHALL be 1 when start bit is 1 or any expected stop bit is 0; data is still stored.
REQ-023 Decode and write SHALL complete in the FrameValid cycle; entry visible at head (RxValid=1) on the cycle after the write edge when FIFO was empty (latency 1).
REQ-024 Pop occurs on a rising edge with RxValid=1 and RxReady=1; head outputs advance to next entry in the following cycle; RxData/flags SHALL hold stable while RxValid=1 and RxReady=0.
REQ-025 When RxValid=0, RxData, RxParityErr, RxFrameErr SHALL be 0.
REQ-026 Full (Count=DEPTH) with FrameValid=1 and no pop: frame dropped, FIFO unchanged, Overrun set next cycle.
REQ-027 Full with FrameValid=1 and pop in same cycle: frame accepted, Count stays DEPTH, no overrun.
REQ-028 Simultaneous push and pop when not full: Count unchanged, ordering preserved.
REQ-029 Read/write pointers SHALL wrap modulo DEPTH; Count SHALL never exceed DEPTH nor underflow.
REQ-030 Overrun SHALL stay 1 until ClearOverrun=1; if a drop and ClearOverrun coincide, Overrun SHALL be 1 (set wins).

Reset
REQ-031 ResetN=0 SHALL immediately clear pointers, Count=0, RxValid=0, RxData=0, RxParityErr=0, RxFrameErr=0, Overrun=0, independent of Clk.
REQ-032 Reset asserted mid-operation SHALL discard all stored entries; a FrameValid coinciding with reset is lost.
REQ-033 First FrameValid accepted on the first rising edge after ResetN deasserts.

Verification
REQ-034 8N1, even parity off: FrameIn=0x2A6 (start 0, data 0x53, stop 1) -> next cycle RxValid=1, RxData=0x53, both errors 0.
REQ-035 7E1: data 0x41, parity bit 1 (wrong, even needs 0) -> RxData=0x41, RxParityErr=1, RxFrameErr=0; same frame with parity 0 -> RxParityErr=0.
REQ-036 8N2 with second stop bit 0 -> RxFrameErr=1; start bit 1 with valid stops -> RxFrameErr=1.
REQ-037 DEPTH=4, RxReady=0, five FrameValid pulses data 1..5 -> Count=4, Overrun=1; draining yields 1,2,3,4 in order, then RxValid=0.
REQ-038 Full FIFO, FrameValid and RxReady same cycle with data 0x77 -> Count stays 4, Overrun stays 0, 0x77 emerges last.
REQ-039 Two entries stored, ResetN pulsed low between clock edges -> outputs and Count 0 immediately; ClearOverrun coincident with a drop leaves Overrun=1.

Source files
------------

// File: rtl/rx_deframe_fifo.sv
// Receive deframer: decodes start/data/parity/stop frames and buffers data plus
// error flags in a small FIFO with registered head outputs and a sticky overrun flag.
module rx_deframe_fifo #(
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 4,
  parameter int FRAME_W = DATA_W + 4
) (
  input  logic                   Clk,
  input  logic                   ResetN,
  input  logic                   FrameValid,
  input  logic [FRAME_W-1:0]     FrameIn,
  input  logic [1:0]             DataLength,
  input  logic [1:0]             ParityType,
  input  logic                   StopBits,
  input  logic                   RxReady,
  input  logic                   ClearOverrun,
  output logic                   RxValid,
  output logic [DATA_W-1:0]      RxData,
  output logic                   RxParityErr,
  output logic                   RxFrameErr,
  output logic                   Overrun,
  output logic [$clog2(DEPTH):0] Count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = DATA_W + 2;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  // Bit select at a run-time position; positions past the frame read as 0.
  function automatic logic frameBit(input logic [FRAME_W-1:0] frame, input int idx);
    logic b;
    b = 1'b0;
    for (int i = 0; i < FRAME_W; i++) begin
      if (i == idx) b = frame[i];
    end
    return b;
  endfunction

  function automatic logic parityOf(input logic [DATA_W-1:0] data, input logic parBit);
    return (^data) ^ parBit;
  endfunction

  logic [EW-1:0]     mem [DEPTH];
  logic [AW-1:0]     wrPtr, rdPtr, nextRd;
  logic [CW-1:0]     nextCount;
  logic [EW-1:0]     newEntry, nextHead;
  logic [DATA_W-1:0] decData;
  logic              parEn, parBit, stop1, stop2, parErr, frmErr;
  logic              full, push, pop, drop, nextValid, nextOverrun;
  int                rawLen, effLen, parIdx, stopIdx;

  // Frame decode: data extraction, parity and start/stop checks from live config.
  always_comb begin
    rawLen  = 32'sd5 + int'(DataLength);
    effLen  = (rawLen > DATA_W) ? DATA_W : rawLen;
    parEn   = (ParityType == 2'b01) || (ParityType == 2'b10);
    decData = '0;
    for (int i = 0; i < DATA_W; i++) begin
      decData[i] = (i < effLen) ? FrameIn[i+1] : 1'b0;
    end
    parIdx  = effLen + 32'sd1;
    stopIdx = parEn ? effLen + 32'sd2 : effLen + 32'sd1;
    parBit  = frameBit(FrameIn, parIdx);
    stop1   = frameBit(FrameIn, stopIdx);
    stop2   = frameBit(FrameIn, stopIdx + 32'sd1);
    case (ParityType)
      2'b01:   parErr = ~parityOf(decData, parBit);
      2'b10:   parErr = parityOf(decData, parBit);
      default: parErr = 1'b0;
    endcase
    frmErr   = FrameIn[0] | ~stop1 | (StopBits & ~stop2);
    newEntry = {frmErr, parErr, decData};
  end

  // FIFO control and next head entry (bypasses the write when it lands at the head).
  always_comb begin
    full  = (Count == DEPTH_C);
    pop   = (Count != '0) & RxReady;
    push  = FrameValid & (~full | pop);
    drop  = FrameValid & full & ~pop;
    nextRd = pop ? rdPtr + AW'(1) : rdPtr;
    case ({push, pop})
      2'b10:   nextCount = Count + CW'(1);
      2'b01:   nextCount = Count - CW'(1);
      default: nextCount = Count;
    endcase
    nextOverrun = drop | (Overrun & ~ClearOverrun);
    nextValid   = (nextCount != '0);
    if (push && (nextRd == wrPtr)) begin
      nextHead = newEntry;
    end else begin
      nextHead = mem[nextRd];
    end
  end

  // Pointers, occupancy, sticky overrun and registered head outputs.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      wrPtr       <= '0;
      rdPtr       <= '0;
      Count       <= '0;
      Overrun     <= 1'b0;
      RxValid     <= 1'b0;
      RxData      <= '0;
      RxParityErr <= 1'b0;
      RxFrameErr  <= 1'b0;
    end else begin
      if (push) wrPtr <= wrPtr + AW'(1);
      rdPtr       <= nextRd;
      Count       <= nextCount;
      Overrun     <= nextOverrun;
      RxValid     <= nextValid;
      RxData      <= nextValid ? nextHead[DATA_W-1:0] : '0;
      RxParityErr <= nextValid & nextHead[DATA_W];
      RxFrameErr  <= nextValid & nextHead[DATA_W+1];
    end
  end

  // Entry storage; contents are only observed through the valid-masked head.
  always_ff @(posedge Clk) begin
    if (push) mem[wrPtr] <= newEntry;
  end

endmodule
